dram_ctrl: RTL and testbench

- Initiator/controller that sits in front of the team's 4K x 8 single-port dram block.
- Accepts burst read/write commands over valid/ready handshakes and drives the dram's address, data_in and we pins.
- Captures the dram's combinational read data and returns it on a registered read-data stream.
- Optionally inserts periodic refresh windows during which no commands are accepted.

---
 rtl/dram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// Burst read/write controller in front of the 4K x 8 single-port dram.
// Optional refresh windows are enabled with DRAM_REFRESH_EN.
module dram_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int LEN_W          = 4,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              refresh_active,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

`ifdef DRAM_REFRESH_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, READ, READ_DRAIN, REFRESH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WRITE, READ, READ_DRAIN
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                alive_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                rd_issue_q, rd_issue_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                ref_pend;

`ifdef DRAM_REFRESH_EN
  localparam int TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int WW = $clog2(REFRESH_CYCLES + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [WW-1:0] win_q, win_d;
  logic          pend_q, pend_d;
  logic          tick;
  logic          ref_clr;

  assign ref_pend       = pend_q;
  assign refresh_active = (state_q == REFRESH);
  assign tick           = (tmr_q == TW'(REFRESH_PERIOD - 1));

  always_comb begin
    tmr_d  = tick ? '0 : tmr_q + TW'(1);
    pend_d = (pend_q && !ref_clr) || tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q  <= '0;
      win_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      win_q  <= win_d;
      pend_q <= pend_d;
    end
  end
`else
  assign ref_pend       = 1'b0;
  assign refresh_active = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rd_issue_d    = 1'b0;
    rd_valid_d    = rd_issue_q;
    rd_last_d     = (state_q == READ_DRAIN);
    // mem_data_out is only valid for the address issued last cycle
    rd_data_d     = rd_issue_q ? mem_data_out : rd_data_q;
    cmd_ready     = 1'b0;
    wd_ready      = 1'b0;
`ifdef DRAM_REFRESH_EN
    win_d         = win_q;
    ref_clr       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cmd_ready = alive_q && !ref_pend;
`ifdef DRAM_REFRESH_EN
        if (ref_pend) begin
          state_d = REFRESH;
          win_d   = WW'(REFRESH_CYCLES - 1);
        end else
`endif
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          mem_we_d      = 1'b1;
          mem_address_d = addr_q;
          mem_data_in_d = wd_data;
          addr_d        = addr_q + ADDR_W'(1);
          cnt_d         = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        mem_address_d = addr_q;
        rd_issue_d    = 1'b1;
        addr_d        = addr_q + ADDR_W'(1);
        cnt_d         = cnt_q - LEN_W'(1);
        if (cnt_q == '0) state_d = READ_DRAIN;
      end
      READ_DRAIN: state_d = IDLE;
`ifdef DRAM_REFRESH_EN
      REFRESH: begin
        if (win_q == '0) begin
          state_d = IDLE;
          ref_clr = 1'b1;
        end else begin
          win_d = win_q - WW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      alive_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rd_issue_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      alive_q       <= 1'b1;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rd_issue_q    <= rd_issue_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl with a behavioural 4K x 8 dram model.
module tb_dram_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 4;
`ifdef DRAM_REFRESH_EN
  localparam int RP = 32;
  localparam int RC = 8;
`else
  localparam int RP = 512;
  localparam int RC = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_last, busy, refresh_active;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_we;

  dram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .refresh_active(refresh_active),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [7:0] dram [4096];
  logic [7:0] refm [4096];

  // 8'hEE stands in for the floating bus while the dram is writing
  assign mem_data_out = mem_we ? 8'hEE : dram[mem_address];

  always @(posedge clk) if (mem_we) dram[mem_address] <= mem_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       first;
    int         acc;
  } rexp_t;
  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int    we_cyc[$];
  int    checks = 0;
  int    errors = 0;
  logic  we_prev = 1'b0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", 64'(rd_valid), 64'(0));
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rd_data", 64'(rd_data), 64'(e.d));
          chk("rd_last", 64'(rd_last), 64'(e.last));
          chk("rd_during_we", 64'(we_prev), 64'(0));
          if (e.first) chk("rd_latency", 64'(cyc - e.acc), 64'(2));
        end
      end
      if (mem_we) begin
        we_cyc.push_back(cyc);
        if (wq.size() == 0) begin
          chk("we_unexpected", 64'(mem_we), 64'(0));
        end else begin
          wexp_t w;
          w = wq.pop_front();
          chk("we_addr", 64'(mem_address), 64'(w.a));
          chk("we_data", 64'(mem_data_in), 64'(w.d));
        end
      end
      we_prev = mem_we;
    end
  end

  task automatic issue(input logic we, input logic [11:0] a,
                       input logic [3:0] len, output int acc,
                       output int waited);
    int t;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = len;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc;
    chk("busy_after_accept", 64'(busy), 64'(1));
    chk("ready_after_accept", 64'(cmd_ready), 64'(0));
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] len);
    int acc, w;
    issue(1'b0, a, len, acc, w);
    if (acc < 0) return;
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      e.d     = refm[a + 12'(i)];
      e.last  = (i == int'(len));
      e.first = (i == 0);
      e.acc   = acc;
      rq.push_back(e);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [3:0] len,
                          input logic [7:0] d [16], input int stall_at,
                          input int stall_n);
    int acc, w, t;
    logic [11:0] ad;
    issue(1'b1, a, len, acc, w);
    if (acc < 0) return;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          wd_valid = 1'b0;
          chk("busy_stall", 64'(busy), 64'(1));
          @(negedge clk);
        end
      end
      wd_valid = 1'b1;
      wd_data  = d[i];
      ad       = a + 12'(i);
      wq.push_back('{ad, d[i]});
      refm[ad] = d[i];
      t = 0;
      while (!wd_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("wd_ready", 64'(wd_ready), 64'(1));
      @(negedge clk);
    end
    wd_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d [16];
    int acc, w, n;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      dram[i] = v;
      refm[i] = v;
    end
    rst = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 0; wd_data = '0;
    #1;
    chk("reset_outputs",
        {cmd_ready, wd_ready, mem_we, mem_address, mem_data_in,
         rd_valid, rd_data, rd_last, busy, refresh_active}, 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", 64'(cmd_ready), 64'(1));
    @(negedge clk);

    // mid-burst async reset; data matches memory so either outcome is safe
    issue(1'b1, 12'h800, 4'd7, acc, w);
    for (int i = 0; i < 3; i++) begin
      wd_valid = 1'b1;
      wd_data  = refm[12'h800 + 12'(i)];
      wq.push_back('{12'h800 + 12'(i), refm[12'h800 + 12'(i)]});
      @(negedge clk);
    end
    chk("busy_mid_burst", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {cmd_ready, wd_ready, mem_we, mem_address, mem_data_in,
         rd_valid, rd_data, rd_last, busy, refresh_active}, 64'(0));
    wd_valid = 1'b0;
    wq.delete();
    rq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // plain 4-beat write then read back
    d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3; d[3] = 8'hA4;
    we_cyc.delete();
    do_write(12'h010, 4'd3, d, -1, 0);
    repeat (2) @(negedge clk);
    chk("write_count", 64'(we_cyc.size()), 64'(4));
    if (we_cyc.size() == 4)
      chk("write_back_to_back", 64'(we_cyc[3] - we_cyc[0]), 64'(3));
    do_read(12'h010, 4'd3);

    // stalled write: 2 idle cycles after beat 2
    d[0] = 8'hB1; d[1] = 8'hB2; d[2] = 8'hB3; d[3] = 8'hB4;
    we_cyc.delete();
    do_write(12'h010, 4'd3, d, 2, 2);
    repeat (2) @(negedge clk);
    chk("stall_count", 64'(we_cyc.size()), 64'(4));
    if (we_cyc.size() == 4) begin
      chk("stall_gap_a", 64'(we_cyc[1] - we_cyc[0]), 64'(1));
      chk("stall_gap_b", 64'(we_cyc[2] - we_cyc[1]), 64'(3));
      chk("stall_gap_c", 64'(we_cyc[3] - we_cyc[2]), 64'(1));
    end
    do_read(12'h010, 4'd3);

    // wrap across 0xFFF -> 0x000 for both writes and reads
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    do_write(12'hFFE, 4'd2, d, -1, 0);
    do_read(12'hFFE, 4'd2);

    // back-to-back write then read of the same location
    d[0] = 8'h5C;
    do_write(12'h100, 4'd0, d, -1, 0);
    issue(1'b0, 12'h100, 4'd0, acc, w);
    chk("b2b_no_wait", 64'(w), 64'(0));
    if (acc >= 0) rq.push_back('{8'h5C, 1'b1, 1'b1, acc});

`ifdef DRAM_REFRESH_EN
    do_read(12'hFF8, 4'd15);
    n = 0;
    while (refresh_active && n < 4 * RP) begin @(negedge clk); n++; end
    n = 0;
    while (!refresh_active && n < 4 * RP) begin @(negedge clk); n++; end
    chk("refresh_seen", 64'(refresh_active), 64'(1));
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h010; cmd_len = 4'd0;
    n = 0;
    while (refresh_active && n < 4 * RC) begin
      if (cmd_ready) chk("ready_in_refresh", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      n++;
    end
    chk("refresh_len", 64'(n), 64'(RC));
    chk("ready_after_refresh", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_after_refresh", 64'(busy), 64'(1));
    rq.push_back('{refm[12'h010], 1'b1, 1'b1, cyc});
`endif

    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      logic [3:0]  len;
      a   = 12'($urandom);
      len = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        do_write(a, len, d, int'($urandom_range(0, 16)),
                 int'($urandom_range(0, 2)));
      end else begin
        do_read(a, len);
      end
    end

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("read_queue_drained", 64'(rq.size()), 64'(0));
    chk("write_queue_drained", 64'(wq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
